// File: rtl/ps2_kbd_ctrl.sv
// Set-2 scan-code controller: pops bytes from the PS/2 receiver FIFO, tracks E0/F0/E1
// prefixes, emits one registered event per complete sequence and keeps a held-key bitmap.
module ps2_kbd_ctrl #(
   parameter int SKIP_E1 = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_ready,
   input  logic [7:0] ps2_data,
   input  logic       ps2_ovf,
   output logic       ps2_rdn,
   input  logic       err_clr,
   output logic       key_valid,
   output logic [7:0] key_code,
   output logic       key_ext,
   output logic       key_break,
   output logic [7:0] key_down,
   output logic       ovf_err,
   output logic       kbd_err
);

   typedef enum logic [1:0] {S_IDLE, S_POP, S_DECODE} state_t;

   state_t     state_q;
   logic [7:0] byte_q;
   logic       ext_q;
   logic       brk_q;
   logic [2:0] skip_q;
   logic [7:0] key_mask_w;
   logic       discard_w;

   function automatic logic [7:0] key_mask(input logic ext, input logic [7:0] code);
      logic [7:0] m;
      m = 8'h00;
      if (ext) begin
         case (code)
            8'h75:   m = 8'h01;
            8'h72:   m = 8'h02;
            8'h6B:   m = 8'h04;
            8'h74:   m = 8'h08;
            default: m = 8'h00;
         endcase
      end else begin
         case (code)
            8'h29:   m = 8'h10;
            8'h5A:   m = 8'h20;
            8'h76:   m = 8'h40;
            8'h1D:   m = 8'h80;
            default: m = 8'h00;
         endcase
      end
      return m;
   endfunction

   function automatic logic is_ctrl_reply(input logic [7:0] code);
      return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hEE);
   endfunction

   // BAT/ack/echo bytes only count as noise when no prefix is pending.
   always_comb begin
      key_mask_w = key_mask(ext_q, byte_q);
      discard_w  = is_ctrl_reply(byte_q) && !ext_q && !brk_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         byte_q    <= 8'h00;
         ext_q     <= 1'b0;
         brk_q     <= 1'b0;
         skip_q    <= 3'd0;
         ps2_rdn   <= 1'b1;
         key_valid <= 1'b0;
         key_code  <= 8'h00;
         key_ext   <= 1'b0;
         key_break <= 1'b0;
         key_down  <= 8'h00;
         ovf_err   <= 1'b0;
         kbd_err   <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         ps2_rdn   <= 1'b1;
         if (err_clr) begin
            ovf_err <= 1'b0;
            kbd_err <= 1'b0;
         end
         case (state_q)
            S_IDLE: begin
               if (ps2_ready) begin
                  byte_q  <= ps2_data;
                  ps2_rdn <= 1'b0;
                  state_q <= S_POP;
               end
            end
            S_POP: state_q <= S_DECODE;
            S_DECODE: begin
               state_q <= S_IDLE;
               if (!ps2_ovf) begin
                  if (skip_q != 3'd0) begin
                     skip_q <= skip_q - 3'd1;
                  end else if ((byte_q == 8'h00) || (byte_q == 8'hFF)) begin
                     kbd_err <= 1'b1;
                     ext_q   <= 1'b0;
                     brk_q   <= 1'b0;
                  end else if (byte_q == 8'hE0) begin
                     ext_q <= 1'b1;
                  end else if (byte_q == 8'hF0) begin
                     brk_q <= 1'b1;
                  end else if (byte_q == 8'hE1) begin
                     key_valid <= 1'b1;
                     key_code  <= 8'hE1;
                     key_ext   <= 1'b0;
                     key_break <= 1'b0;
                     skip_q    <= 3'(SKIP_E1);
                     ext_q     <= 1'b0;
                     brk_q     <= 1'b0;
                  end else if (!discard_w) begin
                     key_valid <= 1'b1;
                     key_code  <= byte_q;
                     key_ext   <= ext_q;
                     key_break <= brk_q;
                     key_down  <= brk_q ? (key_down & ~key_mask_w) : (key_down | key_mask_w);
                     ext_q     <= 1'b0;
                     brk_q     <= 1'b0;
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
         // Overflow may have dropped break codes, so all held state is untrustworthy.
         if (ps2_ovf) begin
            ovf_err  <= 1'b1;
            ext_q    <= 1'b0;
            brk_q    <= 1'b0;
            skip_q   <= 3'd0;
            key_down <= 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Scoreboard bench for ps2_kbd_ctrl: a queue-based receiver FIFO feeds the DUT, a
// sequence-level model predicts events, and a monitor compares each key_valid pulse.
module tb_ps2_kbd_ctrl;
   localparam int SKIP = 7;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ps2_ready = 1'b0;
   logic [7:0] ps2_data = 8'h00;
   logic       ps2_ovf = 1'b0;
   logic       err_clr = 1'b0;
   logic       ps2_rdn;
   logic       key_valid;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;
   logic [7:0] key_down;
   logic       ovf_err;
   logic       kbd_err;

   ps2_kbd_ctrl #(.SKIP_E1(SKIP)) dut (
      .clk(clk), .rst(rst), .ps2_ready(ps2_ready), .ps2_data(ps2_data),
      .ps2_ovf(ps2_ovf), .ps2_rdn(ps2_rdn), .err_clr(err_clr),
      .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
      .key_break(key_break), .key_down(key_down), .ovf_err(ovf_err), .kbd_err(kbd_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic [7:0] down;
   } ev_t;

   int         tests = 0;
   int         fails = 0;
   int         cyc = 0;
   int         ev_cnt = 0;
   ev_t        sb[$];
   logic [7:0] fifo[$];
   logic [7:0] pend[$];
   bit         rdn_prev_low = 1'b0;

   // Reference model state: sequence-level view of the keyboard protocol.
   bit         m_ext = 1'b0;
   bit         m_brk = 1'b0;
   int         m_skip = 0;
   logic [7:0] m_down = 8'h00;
   bit         m_kbd = 1'b0;
   bit         m_ovf = 1'b0;
   logic [8:0] ktab [8] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h029, 9'h05A, 9'h076, 9'h01D};

   function automatic void model_byte(input logic [7:0] b);
      ev_t e;
      if (m_skip > 0) begin
         m_skip--;
         return;
      end
      if (b == 8'h00 || b == 8'hFF) begin
         m_kbd = 1'b1; m_ext = 1'b0; m_brk = 1'b0;
         return;
      end
      if (b == 8'hE0) begin m_ext = 1'b1; return; end
      if (b == 8'hF0) begin m_brk = 1'b1; return; end
      if (b == 8'hE1) begin
         e = {8'hE1, 1'b0, 1'b0, m_down};
         sb.push_back(e);
         m_skip = SKIP; m_ext = 1'b0; m_brk = 1'b0;
         return;
      end
      if ((b == 8'hAA || b == 8'hFA || b == 8'hEE) && !m_ext && !m_brk) return;
      for (int k = 0; k < 8; k++)
         if (ktab[k] == {m_ext, b}) m_down[k] = !m_brk;
      e = {b, m_ext, m_brk, m_down};
      sb.push_back(e);
      m_ext = 1'b0; m_brk = 1'b0;
   endfunction

   function automatic void model_ovf();
      m_ovf = 1'b1; m_ext = 1'b0; m_brk = 1'b0; m_skip = 0; m_down = 8'h00;
   endfunction

   function automatic void model_reset();
      m_ovf = 1'b0; m_kbd = 1'b0; m_ext = 1'b0; m_brk = 1'b0; m_skip = 0; m_down = 8'h00;
      sb.delete();
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      model_byte(b);
      pend.push_back(b);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((fifo.size() != 0 || pend.size() != 0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         tests++; fails++;
         $display("FAIL idle_timeout: fifo still holds %0d bytes after %0d cycles", fifo.size(), n);
      end
      repeat (5) @(negedge clk);
   endtask

   function automatic logic [21:0] out_vec();
      return {ps2_rdn, key_valid, key_code, key_ext, key_break, key_down, ovf_err, kbd_err};
   endfunction

   function automatic logic [7:0] pick();
      int r = $urandom_range(0, 15);
      logic [7:0] b;
      case (r)
         0, 1:          b = 8'hE0;
         2:             b = 8'hF0;
         3:             b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h29;
         4, 5, 6, 7, 8: b = ktab[$urandom_range(0, 7)][7:0];
         9:             b = ($urandom_range(0, 1) == 0) ? 8'hAA : (($urandom_range(0, 1) == 0) ? 8'hFA : 8'hEE);
         10:            b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
         default:       b = 8'($urandom_range(1, 254));
      endcase
      return b;
   endfunction

   // Receiver FIFO: pops on a sampled low rdn, shares the controller's reset.
   always @(posedge clk) begin
      if (rst) begin
         fifo.delete();
         pend.delete();
      end else begin
         if (!ps2_rdn && fifo.size() != 0) void'(fifo.pop_front());
         while (pend.size() != 0) fifo.push_back(pend.pop_front());
      end
      ps2_ready <= (fifo.size() != 0);
      ps2_data  <= (fifo.size() != 0) ? fifo[0] : 8'h00;
   end

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      ev_t e;
      if (!rst) begin
         if (key_valid) begin
            ev_cnt++;
            tests++;
            if (sb.size() == 0) begin
               fails++;
               $display("FAIL event_unexpected: got code %0h ext %0b brk %0b expected no event",
                        key_code, key_ext, key_break);
            end else begin
               e = sb.pop_front();
               if ({key_code, key_ext, key_break, key_down} !== e) begin
                  fails++;
                  $display("FAIL event: got code %0h ext %0b brk %0b down %0h expected code %0h ext %0b brk %0b down %0h",
                           key_code, key_ext, key_break, key_down, e.code, e.ext, e.brk, e.down);
               end
            end
         end
         if (!ps2_rdn) begin
            tests++;
            if (!ps2_ready || rdn_prev_low) begin
               fails++;
               $display("FAIL rdn_strobe: got rdn low with ready %0b prev_low %0b expected ready 1 prev_low 0",
                        ps2_ready, rdn_prev_low);
            end
         end
         rdn_prev_low = !ps2_rdn;
      end else begin
         rdn_prev_low = 1'b0;
      end
   end

   initial begin
      int r, v, lows, base;
      bit found;

      repeat (3) @(negedge clk);
      check("reset_outputs", 32'(out_vec()), 32'h200000);
      rst = 1'b0;
      @(negedge clk);

      // Single make code: latency and single pop strobe.
      send(8'h1C);
      r = -1; v = -1; lows = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ps2_ready && r < 0) r = cyc;
         if (!ps2_rdn) lows++;
         if (key_valid) begin v = cyc; break; end
      end
      check("latency_1c", 32'(v - r), 32'd3);
      check("rdn_low_cycles", 32'(lows), 32'd1);
      wait_idle();

      // Extended make then extended break of the up arrow.
      base = ev_cnt;
      send(8'hE0); send(8'h75);
      wait_idle();
      check("up_held", 32'(key_down[0]), 32'd1);
      send(8'hE0); send(8'hF0); send(8'h75);
      wait_idle();
      check("up_released", 32'(key_down[0]), 32'd0);
      check("up_event_count", 32'(ev_cnt - base), 32'd2);

      // Pause sequence swallows its tail, then space.
      base = ev_cnt;
      foreach (ktab[k]) if (k == 0) begin end
      send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
      send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
      send(8'h29);
      wait_idle();
      check("pause_event_count", 32'(ev_cnt - base), 32'd2);
      check("space_held", 32'(key_down[4]), 32'd1);

      // Overflow clears the bitmap; set beats clear.
      ps2_ovf = 1'b1; model_ovf();
      @(negedge clk);
      ps2_ovf = 1'b0;
      check("ovf_set", 32'(ovf_err), 32'd1);
      check("ovf_bitmap_clear", 32'(key_down), 32'd0);
      err_clr = 1'b1; ps2_ovf = 1'b1; model_ovf();
      @(negedge clk);
      err_clr = 1'b0; ps2_ovf = 1'b0;
      check("ovf_set_wins", 32'(ovf_err), 32'd1);
      err_clr = 1'b1; m_ovf = 1'b0; m_kbd = 1'b0;
      @(negedge clk);
      err_clr = 1'b0;
      check("ovf_cleared", 32'(ovf_err), 32'd0);

      // Keyboard error byte: flag only, next byte still decoded.
      base = ev_cnt;
      send(8'hFF); send(8'h5A);
      wait_idle();
      check("kbd_err_set", 32'(kbd_err), 32'd1);
      check("kbd_err_event_count", 32'(ev_cnt - base), 32'd1);
      err_clr = 1'b1; m_kbd = 1'b0;
      @(negedge clk);
      err_clr = 1'b0;
      check("kbd_err_cleared", 32'(kbd_err), 32'd0);

      // Reset during a pop after E0 has been latched as a prefix.
      send(8'hE0);
      wait_idle();
      send(8'h12);
      found = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!ps2_rdn) begin found = 1'b1; break; end
      end
      check("pop_seen_before_reset", 32'(found), 32'd1);
      rst = 1'b1;
      #1;
      model_reset();
      check("reset_mid_pop", 32'(out_vec()), 32'h200000);
      @(negedge clk);
      check("reset_hold", 32'(out_vec()), 32'h200000);
      rst = 1'b0;
      @(negedge clk);
      base = ev_cnt;
      send(8'h75);
      wait_idle();
      check("post_reset_event_count", 32'(ev_cnt - base), 32'd1);

      // Randomized byte stream with bursts, gaps and occasional overflow.
      for (int i = 0; i < 400; i++) begin
         send(pick());
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 6)) @(negedge clk);
         if (i % 100 == 99) begin
            wait_idle();
            check("rand_bitmap", 32'(key_down), 32'(m_down));
            ps2_ovf = 1'b1; model_ovf();
            @(negedge clk);
            ps2_ovf = 1'b0;
            check("rand_ovf_bitmap", 32'(key_down), 32'd0);
            err_clr = 1'b1; m_ovf = 1'b0; m_kbd = 1'b0;
            @(negedge clk);
            err_clr = 1'b0;
         end
      end
      wait_idle();
      check("rand_final_bitmap", 32'(key_down), 32'(m_down));
      check("rand_kbd_err", 32'(kbd_err), 32'(m_kbd));
      check("rand_ovf_err", 32'(ovf_err), 32'(m_ovf));
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
